// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: 8-way round-robin arbiter with grant lock and hold timeout (clk, areset, req[7:0], done -> gnt[7:0], gnt_valid, gnt_id[2:0], timeout)
module rr_priority_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       areset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic [2:0] gnt_id,
    output logic       timeout
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [7:0] MAX = 8'(MAX_HOLD);
    logic [0:0] state;
    logic [2:0] ptr, off, win;
    logic [7:0] hold, rot;
    logic       rel, expire;
    assign rot = 8'({req, req} >> ptr);
    always_comb begin
        off = '0;
        for (int i = 7; i >= 0; i--) off = rot[i] ? 3'(i) : off;
    end
    assign win       = ptr + off;
    assign rel       = done || !req[gnt_id];
    assign expire    = hold == MAX;
    assign gnt_valid = state == BUSY;
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state   <= IDLE;
            ptr     <= '0;
            hold    <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == IDLE) begin
                if (|req) begin
                    state  <= BUSY;
                    gnt    <= 8'b1 << win;
                    gnt_id <= win;
                    hold   <= 8'd1;
                end
            end else if (rel || expire) begin
                state   <= IDLE;
                gnt     <= '0;
                ptr     <= gnt_id + 3'd1;
                timeout <= !rel;
            end else begin
                hold <= hold + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb_rr_priority_arbiter: scoreboard bench with a behavioural arbiter model and random plus directed stimulus
module tb_rr_priority_arbiter;
    localparam int MAXH = 4;
    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_id;
    logic       timeout;
    typedef struct {
        logic [7:0] g;
        logic       v;
        logic [2:0] id;
        logic       to;
    } exp_t;
    exp_t q[$];
    int total = 0;
    int bad = 0;
    int m_owner = -1;
    int m_ptr = 0;
    int m_hold = 0;
    int m_id = 0;
    bit m_to = 0;
    rr_priority_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk(clk), .areset(areset), .req(req), .done(done),
        .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .timeout(timeout)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic exp_t m_out();
        exp_t e;
        e.g  = m_owner >= 0 ? 8'(1 << m_owner) : 8'h00;
        e.v  = m_owner >= 0;
        e.id = 3'(m_id);
        e.to = m_to;
        return e;
    endfunction
    task automatic m_reset();
        m_owner = -1;
        m_ptr = 0;
        m_hold = 0;
        m_id = 0;
        m_to = 0;
    endtask
    task automatic m_step(input logic [7:0] r, input logic d);
        m_to = 0;
        if (m_owner < 0) begin
            for (int i = 0; i < 8; i++) begin
                if (m_owner < 0 && r[(m_ptr + i) % 8]) begin
                    m_owner = (m_ptr + i) % 8;
                    m_id = m_owner;
                    m_hold = 1;
                end
            end
        end else if (d || !r[m_owner] || m_hold == MAXH) begin
            m_to = !(d || !r[m_owner]);
            m_ptr = (m_owner + 1) % 8;
            m_owner = -1;
        end else begin
            m_hold++;
        end
    endtask
    task automatic drive(input logic [7:0] r, input logic d);
        @(negedge clk);
        areset = 1'b0;
        req = r;
        done = d;
        m_step(r, d);
        q.push_back(m_out());
    endtask
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("gnt", gnt, e.g);
                check("gnt_valid", {7'b0, gnt_valid}, {7'b0, e.v});
                check("gnt_id", {5'b0, gnt_id}, {5'b0, e.id});
                check("timeout", {7'b0, timeout}, {7'b0, e.to});
            end
        end
    end
    initial begin
        logic [7:0] r;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_gnt", gnt, 8'h00);
        check("reset_valid", {7'b0, gnt_valid}, 8'h00);
        check("reset_id", {5'b0, gnt_id}, 8'h00);
        check("reset_timeout", {7'b0, timeout}, 8'h00);
        m_reset();
        drive(8'h81, 0);
        drive(8'h81, 0);
        drive(8'h81, 1);
        repeat (3) drive(8'h81, 0);
        drive(8'h81, 1);
        drive(8'h00, 0);
        repeat (20) drive(8'hFF, 1);
        drive(8'h00, 0);
        repeat (7) drive(8'h08, 0);
        repeat (4) drive(8'h28, 0);
        repeat (7) drive(8'h20, 0);
        drive(8'h00, 0);
        drive(8'h01, 0);
        for (int i = 0; i < 6; i++) drive(8'h01, (m_owner >= 0 && m_hold == MAXH) ? 1'b1 : 1'b0);
        drive(8'h00, 0);
        for (int i = 0; i < 12 && !(m_owner == 2 && m_hold == 2); i++) drive(8'h04, 0);
        drive(8'h00, 0);
        drive(8'h09, 0);
        drive(8'h09, 1);
        drive(8'h00, 0);
        for (int i = 0; i < 12 && m_owner != 4; i++) drive(8'h10, 0);
        drive(8'h10, 0);
        @(negedge clk);
        #2;
        areset = 1'b1;
        #1;
        check("async_gnt", gnt, 8'h00);
        check("async_valid", {7'b0, gnt_valid}, 8'h00);
        check("async_id", {5'b0, gnt_id}, 8'h00);
        m_reset();
        q.push_back(m_out());
        drive(8'h90, 0);
        drive(8'h90, 1);
        drive(8'h00, 0);
        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) r = 8'($urandom);
            drive(r, $urandom_range(7) == 0);
        end
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_priority_arbiter.md
# rr_priority_arbiter

Eight-requester round-robin arbiter with grant locking and a hold timeout. Each arbitration cycle applies a rotating-priority encode to the request vector. The search starts one position past the last granted requester. The winner keeps the grant until it signals `done`, drops its request, or exceeds `MAX_HOLD` cycles. The block sits in front of a shared single-ported resource and gives requester index 0..7 one-hot ownership of it.

## Interface
- `MAX_HOLD`, default 16: maximum number of cycles a grant may be held. Legal range 1..255.
- `clk`  input  1  clock; all state updates on the rising edge.
- `areset`  input  1  asynchronous, active-high reset.
- `req`  input  8  request vector; bit i is requester i.
- `done`  input  1  current owner releases the resource; ignored unless `gnt_valid`=1.
- `gnt`  output  8  one-hot grant, registered; all zero when idle.
- `gnt_valid`  output  1  high while a grant is held; equals OR of `gnt`.
- `gnt_id`  output  3  binary index of the current or last owner.
- `timeout`  output  1  one-cycle pulse when a grant is revoked by hold expiry.

## Operation
- State machine has two states, IDLE and BUSY. An internal 3-bit pointer `ptr` holds the highest-priority index for the next arbitration.
- IDLE:
  - If `req`=0, stay in IDLE with `gnt`=0.
  - Otherwise, pick the winner w as the first set bit of `req` in the order ptr, ptr+1, …, ptr+7, taken mod 8.
  - Next cycle: `gnt`=1<<w, `gnt_id`=w, `gnt_valid`=1, hold counter=1, state BUSY.
- BUSY: evaluate each cycle in this priority order.
  1. `done`=1 or `req[gnt_id]`=0: release.
  2. Hold counter == `MAX_HOLD`: release and pulse `timeout` on the next cycle.
  3. Otherwise, increment the hold counter and keep the grant.
- On release: next cycle `gnt`=0, `gnt_valid`=0, `ptr`=`gnt_id`+1 mod 8 (3-bit wrap; 7 goes to 0), state IDLE. `gnt_id` keeps the last owner.
- A released requester may win again only if no other requester is pending. Rotation places it last in the search order.
- The hold counter is 8 bits. The grant is held for at most `MAX_HOLD` cycles with `gnt` high.
- `done` and timeout in the same cycle: `done` wins, and `timeout` stays low.
- Request changes in non-granted bits while BUSY have no effect until the next IDLE cycle.
- Reset values: `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `timeout`=0, `ptr`=0, hold counter=0, state IDLE.
- `areset` asserted mid-grant clears all outputs immediately, without waiting for a clock edge. The first arbitration after reset treats index 0 as highest priority.

## Timing
- Grant latency: `req` sampled in IDLE at edge t gives `gnt` at edge t+1 (one cycle).
- Release latency: `done` sampled at edge t drops `gnt` at edge t+1.
- Release-to-next-grant: one mandatory IDLE cycle.
  - Release at edge t: IDLE during t+1, next grant at t+2.
  - Back-to-back requesters therefore see a 1-cycle bubble.
- Timeout: grant first visible at edge g is held during cycles g..g+MAX_HOLD-1. It drops, with `timeout`=1, at edge g+MAX_HOLD. `timeout` clears on the following edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Leaving `areset` is synchronous. The first arbitration happens on the first rising edge with `areset` low.

## Test plan
- Reset priority: after reset, `req`=8'b1000_0001 → one cycle later `gnt`=8'h01, `gnt_id`=0. After `done`, idle cycle, then `gnt`=8'h80, `gnt_id`=7.
- Rotation and wrap: `req`=8'hFF held, `done` pulsed each time `gnt_valid`=1 → `gnt_id` sequence 0,1,2,…,7,0 with one idle cycle between grants.
- Timeout with `MAX_HOLD`=4:
  - requester 3 holds `req` with no `done` → `gnt`=8'h08 for exactly 4 cycles, then `gnt`=0 and `timeout`=1 for one cycle.
  - requester 5 also pending → next grant is 8'h20.
- Done/timeout collision: assert `done` on the cycle the counter reaches `MAX_HOLD` → `gnt` drops and `timeout` stays 0.
- Request drop: owner 2 deasserts `req[2]` mid-grant with `done`=0 → `gnt`=0 next cycle, and `ptr` moves so index 3 has highest priority.
- Async reset mid-grant: assert `areset` between clock edges while `gnt`=8'h10 → `gnt`=0, `gnt_valid`=0, `gnt_id`=0 before the next edge. After release, `req`=8'h90 grants index 4.
